sha3_sponge_ctrl: RTL

SHA3_SPONGE_CTRL -- requirements
Module: sha3_sponge_ctrl

---
 rtl/sha3_pkg.sv | 22 ++
 rtl/sha3_pad_lane.sv | 26 ++
 rtl/sha3_sponge_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// SHA-3 sponge shared types and constants.
// Lane (x,y) lives at linear index 5y+x in the 1600-bit state.
package sha3_pkg;

    localparam int         LANE_W     = 64;
    localparam int         NUM_LANES  = 25;
    localparam logic [7:0] DOMAIN_PAD = 8'h06;
    localparam logic [7:0] FINAL_PAD  = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        PERM,
        SQUEEZE
    } state_t;

    function automatic int lane_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/sha3_pad_lane.sv
// Byte-masks a message lane and overlays the SHA-3 domain/final padding bytes.
// Domain byte lands at position in_bytes; final byte at byte 7 when final_lane.
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  logic [LANE_W-1:0] in_data,
    input  logic [3:0]        in_bytes,
    input  logic              mask_en,
    input  logic              dom_en,
    input  logic              final_lane,
    output logic [LANE_W-1:0] lane_out
);

    always_comb begin
        lane_out = in_data;
        for (int b = 0; b < 8; b++) begin
            if (mask_en && (4'(b) >= in_bytes))
                lane_out[8*b +: 8] = '0;
            if (dom_en && (4'(b) == in_bytes))
                lane_out[8*b +: 8] = lane_out[8*b +: 8] ^ DOMAIN_PAD;
        end
        if (final_lane)
            lane_out[63:56] = lane_out[63:56] ^ FINAL_PAD;
    end

endmodule

// File: rtl/sha3_sponge_ctrl.sv
// SHA-3 sponge controller: absorbs 64-bit words, pads, drives an external
// Keccak-f[1600] permutation and presents the digest with valid/ready.
module sha3_sponge_ctrl
    import sha3_pkg::*;
#(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        in_valid,
    input  logic [63:0]                 in_data,
    input  logic                        in_last,
    input  logic [3:0]                  in_bytes,
    output logic                        in_ready,
    output logic                        perm_start,
    output logic [1599:0]               perm_din,
    input  logic                        perm_done,
    input  logic [1599:0]               perm_dout,
    output logic [64*OUT_LANES-1:0]     digest,
    output logic                        digest_valid,
    input  logic                        digest_ready
);

    localparam logic [4:0] RATE_L  = 5'(RATE_LANES);
    localparam int         FIN_BIT = LANE_W * RATE_LANES - 8;

    state_t                  fsm, fsm_n;
    logic [1599:0]           st, st_n;
    logic [4:0]              cnt, cnt_n, cnt_eff;
    logic                    start_n, fin_q, fin_n, pend_q, pend_n, dv_n;
    logic [64*OUT_LANES-1:0] dig_n;
    logic [LANE_W-1:0]       pad_din, pad_out;
    logic [3:0]              pad_bytes;
    logic                    pad_mask, pad_dom, pad_fin, in_pad, xfer;

    assign in_ready  = nrst && (fsm == IDLE || fsm == ABSORB);
    assign xfer      = in_valid && in_ready;
    assign in_pad    = (fsm == PAD);
    assign cnt_eff   = (fsm == IDLE) ? '0 : cnt;
    assign pad_din   = in_pad ? '0 : in_data;
    assign pad_bytes = in_pad ? '0 : in_bytes;
    assign pad_mask  = in_pad || in_last;
    assign pad_dom   = in_pad || (in_last && in_bytes < 4'd8);
    assign pad_fin   = pad_dom && (cnt_eff == RATE_L - 5'd1);
    assign perm_din  = st;

    sha3_pad_lane u_pad (
        .in_data    (pad_din),
        .in_bytes   (pad_bytes),
        .mask_en    (pad_mask),
        .dom_en     (pad_dom),
        .final_lane (pad_fin),
        .lane_out   (pad_out)
    );

    always_comb begin
        fsm_n   = fsm;
        st_n    = st;
        cnt_n   = cnt;
        start_n = 1'b0;
        fin_n   = fin_q;
        pend_n  = pend_q;
        dv_n    = digest_valid;
        dig_n   = digest;
        unique case (fsm)
            IDLE, ABSORB: begin
                if (fsm == IDLE) begin
                    st_n   = '0;
                    cnt_n  = '0;
                    fin_n  = 1'b0;
                    pend_n = 1'b0;
                end
                if (xfer) begin
                    st_n[LANE_W*cnt_eff +: LANE_W] =
                        st_n[LANE_W*cnt_eff +: LANE_W] ^ pad_out;
                    // 0x80 lands in a different lane than the data word
                    if (pad_dom && !pad_fin)
                        st_n[FIN_BIT +: 8] = st_n[FIN_BIT +: 8] ^ FINAL_PAD;
                    cnt_n = cnt_eff + 5'd1;
                    fsm_n = ABSORB;
                    if (in_last && !pad_dom) begin
                        fsm_n = PAD;
                    end else if (in_last || cnt_n == RATE_L) begin
                        fsm_n   = PERM;
                        start_n = 1'b1;
                        cnt_n   = '0;
                        fin_n   = in_last;
                    end
                end
            end
            PAD: begin
                fsm_n   = PERM;
                start_n = 1'b1;
                cnt_n   = '0;
                if (cnt == RATE_L) begin
                    pend_n = 1'b1;
                end else begin
                    st_n[LANE_W*cnt +: LANE_W] =
                        st[LANE_W*cnt +: LANE_W] ^ pad_out;
                    if (!pad_fin)
                        st_n[FIN_BIT +: 8] = st_n[FIN_BIT +: 8] ^ FINAL_PAD;
                    fin_n = 1'b1;
                end
            end
            PERM: begin
                if (perm_done) begin
                    st_n = perm_dout;
                    if (fin_q) begin
                        dig_n = perm_dout[64*OUT_LANES-1:0];
                        dv_n  = 1'b1;
                        fsm_n = SQUEEZE;
                    end else if (pend_q) begin
                        pend_n = 1'b0;
                        fsm_n  = PAD;
                    end else begin
                        fsm_n = ABSORB;
                    end
                end
            end
            SQUEEZE: begin
                if (digest_ready) begin
                    dv_n  = 1'b0;
                    fsm_n = IDLE;
                end
            end
            default: fsm_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm          <= IDLE;
            st           <= '0;
            cnt          <= '0;
            perm_start   <= 1'b0;
            fin_q        <= 1'b0;
            pend_q       <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
        end else begin
            fsm          <= fsm_n;
            st           <= st_n;
            cnt          <= cnt_n;
            perm_start   <= start_n;
            fin_q        <= fin_n;
            pend_q       <= pend_n;
            digest_valid <= dv_n;
            digest       <= dig_n;
        end
    end

endmodule
